level_pwm_gen: RTL
==================

// Module: level_pwm_gen
// PURPOSE
//   Downstream consumer of the 4-bit saturating up/down counter value.
//   - Converts the counter value into a glitch-free PWM duty.
//   - Samples the level only at frame boundaries.
//   - Tracks level direction between frames and flags turnarounds (peak/trough).
//   - Sits between the counter and the LED/analog output pad.
// PARAMETERS
//   LVL_W     4   width of level_in; frame = 2**LVL_W slots
//   PRESCALE  1   clk cycles per PWM slot; legal range >=1
//   TURN_W    8   width of turnaround counter (TURN_CNT_EN only)
// PORTS
//   clk         in   1       single clock, rising edge
//   rst         in   1       synchronous, active-high reset
//   level_in    in   LVL_W   counter value; sampled only at frame end
//   pwm_out     out  1       PWM output
//   frame_start out  1       1-cycle pulse on the level-load cycle
//   dir         out  2       2'b00 hold, 2'b01 up, 2'b10 down
//   turn_pulse  out  1       1-cycle pulse on a direction reversal
//   turn_cnt    out  TURN_W  saturating reversal count (TURN_CNT_EN only)
// BEHAVIOUR
//   - Reset values (rst sampled high at a clk edge): all outputs 0.
//     - Internal state reset: pre_cnt=0, slot=0, level_q=0, FSM=IDLE.
//     - Reset mid-frame aborts the frame; the next frame starts at slot 0.
//   - Timebase:
//     - pre_cnt counts 0..PRESCALE-1; tick = (pre_cnt==PRESCALE-1).
//     - slot increments on tick and wraps from 2**LVL_W-1 to 0.
//     - load = tick && slot==2**LVL_W-1 (last cycle of the frame).
//   - On load:
//     - level_q <= level_in. level_in changes at any other time are ignored.
//     - frame_start = load (combinational, 1 cycle).
//   - pwm_out = (slot < level_q): decode of registers, no added latency.
//     - level 0: always low. level L: high for the first L*PRESCALE cycles of each frame.
//     - Max duty is (2**LVL_W-1)/2**LVL_W; full-on is unreachable by design.
//     - First frame after reset is all-low because level_q=0.
//   - Direction FSM, evaluated only on load; compares new = level_in vs old = level_q:
//     - IDLE: new>old -> RISE, dir=01; new<old -> FALL, dir=10; equal -> IDLE, dir=00.
//     - RISE: new<old -> FALL, turn_pulse; new>old -> RISE, dir=01; equal -> RISE, dir=00.
//     - FALL: mirror of RISE.
//     - Equal levels never clear the RISE/FALL history.
//     - dir and turn_pulse are registered at the load edge.
//     - turn_pulse is high only in the cycle after load, i.e. the first cycle of slot 0.
//   - Width rules: slot is LVL_W bits; the compare is unsigned LVL_W-bit; no arithmetic overflow paths.
// CONFIGURATION
//   LEVEL_PWM_TURN_CNT_EN defined:
//     - turn_cnt port exists; it increments in the same cycle turn_pulse is high.
//     - It saturates at 2**TURN_W-1 and is cleared only by rst.
//   Undefined:
//     - turn_cnt port and its counter are absent; all other behaviour is identical.
// STRUCTURE
//   Package level_pwm_pkg:
//     - DIR_HOLD/DIR_UP/DIR_DOWN 2-bit constants.
//     - FSM state encodings ST_IDLE/ST_RISE/ST_FALL (2-bit).
//   Sub-module level_pwm_timebase:
//     - Contains the prescaler and slot counter.
//     - Outputs slot, tick, load.
//   Top level: level_q register, compare, direction FSM, optional counter.
// TESTING
//   - PRESCALE=1, level_in=5 held from reset release:
//     - Cycles 0-15 pwm low; frame_start at cycle 15.
//     - Each later 16-cycle frame: 5 high, then 11 low.
//   - PRESCALE=3, level_in=15:
//     - After the first frame, pwm is high 45 cycles and low 3 cycles per 48-cycle frame.
//   - level_in changed 5->9 mid-frame:
//     - Duty stays 5 until the next frame_start, then becomes 9.
//     - At that load dir=01.
//   - Frame levels 0,4,8,15,15,12,3,0,0,7:
//     - turn_pulse after the loads of 12 and 7 only.
//     - The first turn_pulse is on the first cycle of the frame that follows the load of 12.
//     - dir=00 on the frames following the 15->15 and 0->0 loads.
//     - With LEVEL_PWM_TURN_CNT_EN, turn_cnt ends at 2.
//   - rst pulsed 1 cycle in slot 7 of a frame at level 10:
//     - All outputs 0 the next cycle; a full all-low frame follows.
//     - FSM is back in IDLE, so the next load produces no turn_pulse.
//   - TURN_W=2, 5 forced reversals: turn_cnt saturates at 3.

Source files
------------

// File: rtl/level_pwm_pkg.sv
// -----------------------------------------------------------------------------
// level_pwm_pkg
//   Shared constants for the level-to-PWM block: direction codes reported on
//   the dir output and the direction-tracking FSM state encodings.
//   Optional feature macro used by the block: LEVEL_PWM_TURN_CNT_EN.
// -----------------------------------------------------------------------------
package level_pwm_pkg;

   // Direction codes driven on dir.
   localparam logic [1:0] DIR_HOLD = 2'b00;
   localparam logic [1:0] DIR_UP   = 2'b01;
   localparam logic [1:0] DIR_DOWN = 2'b10;

   // Direction-tracking FSM states; the encoding is visible on state_dbg.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RISE = 2'b01,
      ST_FALL = 2'b10
   } dir_state_e;

   // Direction code for a comparison of the new level against the old one.
   function automatic logic [1:0] dir_code(input logic gt, input logic lt);
      logic [1:0] code;
      code = DIR_HOLD;
      if (gt)      code = DIR_UP;
      else if (lt) code = DIR_DOWN;
      return code;
   endfunction

endpackage

// File: rtl/level_pwm_gen_timebase.sv
// -----------------------------------------------------------------------------
// level_pwm_gen_timebase
//   Prescaler plus slot counter that define the PWM frame.
//   A frame is 2**LVL_W slots, each slot PRESCALE clk cycles long.
// Ports
//   clk   in   1      rising-edge clock
//   rst   in   1      synchronous active-high reset (pre_cnt=0, slot=0)
//   slot  out  LVL_W  current slot index within the frame
//   tick  out  1      last clk cycle of the current slot
//   load  out  1      last clk cycle of the frame (tick in the final slot)
// -----------------------------------------------------------------------------
module level_pwm_gen_timebase #(
   parameter int unsigned LVL_W    = 4,
   parameter int unsigned PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst,
   output logic [LVL_W-1:0] slot,
   output logic             tick,
   output logic             load
);

   // A single-cycle slot still needs a 1-bit counter that simply stays at 0.
   localparam int unsigned     PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]   PRE_MAX  = PW'(PRESCALE - 1);
   localparam logic [LVL_W-1:0] SLOT_MAX = '1;

   logic [PW-1:0]    pre_cnt;
   logic [LVL_W-1:0] slot_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         pre_cnt <= '0;
         slot_q  <= '0;
      end else if (tick) begin
         pre_cnt <= '0;
         // Natural LVL_W-bit wrap takes the last slot back to slot 0.
         slot_q  <= slot_q + 1'b1;
      end else begin
         pre_cnt <= pre_cnt + 1'b1;
      end
   end

   assign tick = (pre_cnt == PRE_MAX);
   assign load = tick && (slot_q == SLOT_MAX);
   assign slot = slot_q;

endmodule

// File: rtl/level_pwm_gen.sv
// -----------------------------------------------------------------------------
// level_pwm_gen
//   Turns the 4-bit saturating counter value into a glitch-free PWM duty for
//   the LED/analog pad. The level is sampled only on the last cycle of each
//   frame, so a duty change never splits a frame. Between frames the block
//   tracks whether the level is rising or falling and pulses on reversals.
// Optional feature: define LEVEL_PWM_TURN_CNT_EN to add the turn_cnt port and
//   its saturating reversal counter; without it the port and counter vanish.
// Ports
//   clk          in   1       rising-edge clock
//   rst          in   1       synchronous active-high reset
//   level_in     in   LVL_W   counter value, sampled at frame end only
//   pwm_out      out  1       PWM output, high while slot < loaded level
//   frame_start  out  1       1-cycle pulse on the level-load cycle
//   dir          out  2       00 hold, 01 up, 10 down (updated at load)
//   turn_pulse   out  1       1-cycle pulse in slot 0 after a reversal
//   turn_cnt     out  TURN_W  saturating reversal count (feature build only)
//   state_dbg    out  2       direction FSM state (ST_IDLE/ST_RISE/ST_FALL)
// -----------------------------------------------------------------------------
module level_pwm_gen
   import level_pwm_pkg::*;
#(
   parameter int unsigned LVL_W    = 4,
   parameter int unsigned PRESCALE = 1,
   parameter int unsigned TURN_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [LVL_W-1:0] level_in,
   output logic             pwm_out,
   output logic             frame_start,
   output logic [1:0]       dir,
   output logic             turn_pulse,
`ifdef LEVEL_PWM_TURN_CNT_EN
   output logic [TURN_W-1:0] turn_cnt,
`endif
   output logic [1:0]       state_dbg
);

   // Elaboration-time guard on the parameter ranges.
   if (PRESCALE < 1 || TURN_W < 1 || LVL_W < 1) begin : g_bad_param
      $error("level_pwm_gen: PRESCALE, TURN_W and LVL_W must be >= 1");
   end

   logic [LVL_W-1:0] slot;
   logic             tick;
   logic             load;

   level_pwm_gen_timebase #(
      .LVL_W    (LVL_W),
      .PRESCALE (PRESCALE)
   ) u_timebase (
      .clk  (clk),
      .rst  (rst),
      .slot (slot),
      .tick (tick),
      .load (load)
   );

   // ---------------------------------------------------------------------------
   // Level register and duty decode
   // ---------------------------------------------------------------------------
   logic [LVL_W-1:0] level_q;

   always_ff @(posedge clk) begin
      if (rst)       level_q <= '0;
      else if (load) level_q <= level_in;
   end

   // Pure decode of registers: no added latency, and since slot never reaches
   // 2**LVL_W the output is never high for a whole frame.
   assign pwm_out     = (slot < level_q);
   assign frame_start = load;

   // ---------------------------------------------------------------------------
   // Direction FSM: evaluated only on load, new level vs. currently held one.
   // ---------------------------------------------------------------------------
   logic lvl_gt;
   logic lvl_lt;

   assign lvl_gt = (level_in > level_q);
   assign lvl_lt = (level_in < level_q);

   dir_state_e state_q;
   dir_state_e state_nxt;
   logic [1:0] dir_q;
   logic [1:0] dir_nxt;
   logic       turn_q;
   logic       turn_nxt;

   // State register; dir and turn_pulse are captured on the same load edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         dir_q   <= DIR_HOLD;
         turn_q  <= 1'b0;
      end else begin
         // turn_pulse lives for exactly the cycle after a load.
         turn_q <= load && turn_nxt;
         if (load) begin
            state_q <= state_nxt;
            dir_q   <= dir_nxt;
         end
      end
   end

   // Next state. Equal levels keep the RISE/FALL history untouched.
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         ST_IDLE: begin
            if (lvl_gt)      state_nxt = ST_RISE;
            else if (lvl_lt) state_nxt = ST_FALL;
         end
         ST_RISE: begin
            if (lvl_lt) state_nxt = ST_FALL;
         end
         ST_FALL: begin
            if (lvl_gt) state_nxt = ST_RISE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Output decode, registered above on load.
   always_comb begin
      dir_nxt  = dir_code(lvl_gt, lvl_lt);
      turn_nxt = 1'b0;
      case (state_q)
         ST_RISE: turn_nxt = lvl_lt;
         ST_FALL: turn_nxt = lvl_gt;
         default: turn_nxt = 1'b0;
      endcase
   end

   assign dir        = dir_q;
   assign turn_pulse = turn_q;
   assign state_dbg  = state_q;

`ifdef LEVEL_PWM_TURN_CNT_EN
   // ---------------------------------------------------------------------------
   // Reversal counter: steps on the same edge that raises turn_pulse, sticks at
   // all-ones, cleared only by rst.
   // ---------------------------------------------------------------------------
   logic [TURN_W-1:0] turn_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         turn_cnt_q <= '0;
      end else if (load && turn_nxt && (turn_cnt_q != {TURN_W{1'b1}})) begin
         turn_cnt_q <= turn_cnt_q + 1'b1;
      end
   end

   assign turn_cnt = turn_cnt_q;
`endif

endmodule
